delay_timer_datapath: RTL and testbench

- Timer datapath paired with the 1101-start-sequence control FSM: consumes that FSM's `shift_ena` and `counting` outputs and produces its `done_counting` input.
- During `shift_ena` it serially loads a DELAY_W-bit delay value, MSB first.
- During `counting` it runs for (delay+1)*TICKS_PER_UNIT cycles, presenting the remaining delay units on `count`.
- Sits directly downstream of the FSM, on the same clock.

---
 rtl/timer_pkg.sv | 9 +
 rtl/unit_prescaler.sv | 21 ++
 rtl/delay_timer_datapath.sv | 54 +++++
 tb/tb_delay_timer_datapath.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared defaults, delay type and prescaler width helper for the delay timer
package timer_pkg;
  localparam int TICKS_PER_UNIT_DEF = 1000;
  localparam int DELAY_W_DEF = 4;
  typedef logic [DELAY_W_DEF-1:0] delay_t;
  function automatic int presc_width(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction
endpackage

// File: rtl/unit_prescaler.sv
// unit_prescaler: counts clock cycles within one delay unit, wrapping at TICKS_PER_UNIT-1
// Ports: clk, reset_n (async active-low), en (count), clr (sync clear, wins over en),
//        presc (current tick count), tick (presc is on the last cycle of the unit)
module unit_prescaler
  import timer_pkg::*;
#(
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
  localparam int PW = presc_width(TICKS_PER_UNIT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  output logic [PW-1:0] presc,
  output logic          tick
);
  assign tick = presc == PW'(TICKS_PER_UNIT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) presc <= '0;
    else presc <= clr ? '0 : en ? (tick ? '0 : presc + PW'(1)) : presc;
endmodule

// File: rtl/delay_timer_datapath.sv
// delay_timer_datapath: serially loaded delay register counted down in units of TICKS_PER_UNIT cycles
// Ports: clk, reset_n (async active-low), data (serial delay bit, MSB first), shift_ena (load),
//        counting (run), done_counting (last cycle of the count), count (remaining delay units),
//        proto_err (sticky protocol error, only when TIMER_PROTO_CHECK_EN is defined)
module delay_timer_datapath
  import timer_pkg::*;
#(
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
  parameter int DELAY_W = DELAY_W_DEF,
  localparam int PW = presc_width(TICKS_PER_UNIT)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data,
  input  logic               shift_ena,
  input  logic               counting,
  output logic               done_counting,
  output logic [DELAY_W-1:0] count
`ifdef TIMER_PROTO_CHECK_EN
  ,
  output logic               proto_err
`endif
);
  logic [DELAY_W-1:0] delay;
  logic [PW-1:0] presc;
  logic tick;
  unit_prescaler #(.TICKS_PER_UNIT(TICKS_PER_UNIT)) u_presc (
    .clk(clk),
    .reset_n(reset_n),
    .en(counting),
    .clr(shift_ena | ~counting),
    .presc(presc),
    .tick(tick)
  );
  // Truncating {delay, data} keeps the shift legal for DELAY_W == 1 as well
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) delay <= '0;
    else if (shift_ena) delay <= DELAY_W'({delay, data});
    else if (counting && tick && delay != '0) delay <= delay - DELAY_W'(1);
  assign count = delay;
  // A simultaneous shift suppresses done even if presc sits on its last tick
  assign done_counting = counting & ~shift_ena & (delay == '0) & (presc == PW'(TICKS_PER_UNIT - 1));
`ifdef TIMER_PROTO_CHECK_EN
  logic shifted;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shifted   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      shifted   <= shifted | shift_ena;
      proto_err <= proto_err | (counting & (shift_ena | ~shifted));
    end
`endif
endmodule

// File: tb/tb_delay_timer_datapath.sv
// tb_delay_timer_datapath: randomized and directed scoreboard bench for delay_timer_datapath
module tb_delay_timer_datapath;
  import timer_pkg::*;
  localparam int T = 1000;
  localparam int W = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic data = 1'b0, shift_ena = 1'b0, counting = 1'b0;
  logic done_counting;
  logic [W-1:0] count;
  logic data1 = 1'b0, shift1 = 1'b0, counting1 = 1'b0;
  logic done1;
  logic [W-1:0] count1;
`ifdef TIMER_PROTO_CHECK_EN
  logic proto_err, proto_err1;
`endif
  int checks = 0, failures = 0, cyc = 0, d = 0;
  int exp_q[$];
  delay_timer_datapath #(.TICKS_PER_UNIT(T), .DELAY_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .shift_ena(shift_ena), .counting(counting),
    .done_counting(done_counting), .count(count)
`ifdef TIMER_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );
  delay_timer_datapath #(.TICKS_PER_UNIT(1), .DELAY_W(W)) dut1 (
    .clk(clk), .reset_n(reset_n), .data(data1), .shift_ena(shift1), .counting(counting1),
    .done_counting(done1), .count(count1)
`ifdef TIMER_PROTO_CHECK_EN
    , .proto_err(proto_err1)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Monitor: every done pulse must match the next scheduled done cycle
  always @(negedge clk)
    if (done_counting) begin
      if (exp_q.size() == 0) chk("unexpected_done", cyc, -1);
      else chk("done_cycle", cyc, exp_q.pop_front());
    end
  function automatic int units_left(input int dd, input int r);
    return (dd - r / T < 0) ? 0 : dd - r / T;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      counting = 1'b0; shift_ena = 1'b0;
    end
  endtask
  task automatic load(input delay_t v);
    for (int i = W - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      counting = 1'b0; shift_ena = 1'b1; data = v[i];
    end
    @(posedge clk); #1;
    shift_ena = 1'b0;
    d = int'(v);
    @(negedge clk);
    chk("count_after_load", int'(count), d);
  endtask
  // Counting for len cycles from a cleared prescaler; a full run schedules exactly one done
  task automatic run(input int len, input bit keep);
    int e;
    e = (d + 1) * T;
    for (int r = 0; r < len; r++) begin
      @(posedge clk); #1;
      counting = 1'b1; shift_ena = 1'b0;
      if (r == 0 && len >= e) exp_q.push_back(cyc + e - 1);
      @(negedge clk);
      chk("count_run", int'(count), units_left(d, r));
    end
    d = units_left(d, len);
    if (!keep) idle(1);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int segs, len, e;
    #3;
    chk("reset_count", int'(count), 0);
    chk("reset_done", int'(done_counting), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    load(4'd11);
    run(12 * T, 0);
    chk("count_zero_after_done", int'(count), 0);
    load(4'd0);
    run(T, 0);
    idle(2);
    load(4'd2);
    run(1500, 0);
    idle(9);
    @(negedge clk);
    chk("count_pause", int'(count), 1);
    run(2 * T, 0);
    load(4'd5);
    run(301, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_done", int'(done_counting), 0);
    counting = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    d = 0;
    run(T, 0);
`ifdef TIMER_PROTO_CHECK_EN
    chk("proto_err_count_no_shift", int'(proto_err), 1);
`endif
    load(4'd0);
    run(T - 1, 1);
    @(posedge clk); #1;
    shift_ena = 1'b1; counting = 1'b1; data = 1'b1;
    @(negedge clk);
    chk("shift_priority_done", int'(done_counting), 0);
    @(posedge clk); #1;
    shift_ena = 1'b0; counting = 1'b0;
    d = 1;
    @(negedge clk);
    chk("shift_priority_count", int'(count), 1);
    run(2 * T, 0);
`ifdef TIMER_PROTO_CHECK_EN
    chk("proto_err_sticky", int'(proto_err), 1);
`endif
    for (int i = W - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      shift1 = 1'b1; data1 = (i < 2);
    end
    @(posedge clk); #1;
    shift1 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      counting1 = 1'b1;
      @(negedge clk);
      chk("t1_count", int'(count1), 3 - r);
      chk("t1_done", int'(done1), int'(r == 3));
      @(posedge clk); #1;
    end
    counting1 = 1'b0;
    @(negedge clk);
    chk("t1_done_after_drop", int'(done1), 0);
    for (int it = 0; it < 4; it++) begin
      load(delay_t'($urandom_range(0, 2)));
      segs = int'($urandom_range(0, 2));
      repeat (segs) begin
        e = (d + 1) * T;
        len = int'($urandom_range(1, (e - 1 < 1500) ? e - 1 : 1500));
        run(len, 0);
        idle(int'($urandom_range(1, 5)));
      end
      run((d + 1) * T, 0);
      idle(2);
    end
    idle(3);
    chk("done_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
